// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_forward_match.sv
// Youngest-first lookup of a register over the live queue entries and the output stage.
module wb_forward_match import wb_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic [ADDR_W-1:0] i_lookup_reg,
  input  wb_entry_t         i_queue [DEPTH],
  input  logic [PTR_W-1:0]  i_head,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_out_valid,
  input  wb_entry_t         i_out_entry,
  output logic              o_pending,
  output logic [DATA_W-1:0] o_data
);

  logic [PTR_W-1:0] w_idx;

  // Visit oldest to youngest so the last hit (the youngest) wins; the output
  // stage is older than every queued entry and is checked first.
  always_comb begin
    o_pending = 1'b0;
    o_data    = '0;
    w_idx     = '0;
    if (i_lookup_reg != ZERO_REG) begin
      if (i_out_valid && (i_out_entry.rd == i_lookup_reg)) begin
        o_pending = 1'b1;
        o_data    = i_out_entry.data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_idx = i_head + PTR_W'(i);
        if ((CNT_W'(i) < i_count) && (i_queue[w_idx].rd == i_lookup_reg)) begin
          o_pending = 1'b1;
          o_data    = i_queue[w_idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue feeding the register file's single write port, one write per
// cycle, with two producers (ALU, memory/multiply) and decode-side forwarding.
module writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aluValid,
  input  logic [ADDR_W-1:0] aluReg,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluReady,
  input  logic              memValid,
  input  logic [ADDR_W-1:0] memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  output logic [ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0] writeData,
  output logic              regWrite,
  input  logic [ADDR_W-1:0] lookupReg,
  output logic              lookupPending,
  output logic [DATA_W-1:0] lookupData,
  output logic [CNT_W-1:0]  count
);

  import wb_pkg::wb_entry_t;
  import wb_pkg::ZERO_REG;

  wb_entry_t        r_queue [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  wb_entry_t        r_out;
  logic             r_out_valid;

  logic [CNT_W-1:0] w_free;
  logic             w_alu_acc;
  logic             w_mem_acc;
  logic             w_alu_push;
  logic             w_mem_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_mem_slot;
  wb_entry_t        w_alu_entry;
  wb_entry_t        w_mem_entry;

  // Readiness looks only at occupancy, never at the same-cycle pop.
  always_comb begin
    w_free   = CNT_W'(DEPTH) - r_count;
    aluReady = (w_free != '0);
    memReady = (w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !aluValid);
  end

  always_comb begin
    w_alu_acc        = aluValid && aluReady;
    w_mem_acc        = memValid && memReady;
    // Writes to register 0 complete the handshake but are dropped here.
    w_alu_push       = w_alu_acc && (aluReg != ZERO_REG);
    w_mem_push       = w_mem_acc && (memReg != ZERO_REG);
    w_pop            = (r_count != '0);
    w_mem_slot       = r_tail + PTR_W'(w_alu_push);
    w_alu_entry.rd   = aluReg;
    w_alu_entry.data = aluData;
    w_mem_entry.rd   = memReg;
    w_mem_entry.data = memData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_queue[i] <= '0;
      end
    end else begin
      if (w_alu_push) begin
        r_queue[r_tail] <= w_alu_entry;
      end
      if (w_mem_push) begin
        r_queue[w_mem_slot] <= w_mem_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_alu_push) + PTR_W'(w_mem_push);
      r_count <= r_count + CNT_W'(w_alu_push) + CNT_W'(w_mem_push) - CNT_W'(w_pop);
    end
  end

  // Output stage: index/data hold their last value when the queue is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out <= r_queue[r_head];
      end
    end
  end

  assign writeRegister = r_out.rd;
  assign writeData     = r_out.data;
  assign regWrite      = r_out_valid;
  assign count         = r_count;

  wb_forward_match #(
    .DEPTH (DEPTH)
  ) u_forward_match (
    .i_lookup_reg (lookupReg),
    .i_queue      (r_queue),
    .i_head       (r_head),
    .i_count      (r_count),
    .i_out_valid  (r_out_valid),
    .i_out_entry  (r_out),
    .o_pending    (lookupPending),
    .o_data       (lookupData)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        aluValid;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memReg;
  logic [31:0] memData;
  logic        memReady;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        regWrite;
  logic [4:0]  lookupReg;
  logic        lookupPending;
  logic [31:0] lookupData;
  logic [2:0]  cnt;

  writeback_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluValid      (aluValid),
    .aluReg        (aluReg),
    .aluData       (aluData),
    .aluReady      (aluReady),
    .memValid      (memValid),
    .memReg        (memReg),
    .memData       (memData),
    .memReady      (memReady),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .regWrite      (regWrite),
    .lookupReg     (lookupReg),
    .lookupPending (lookupPending),
    .lookupData    (lookupData),
    .count         (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: list of accepted writes (oldest first) plus the write-port stage.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } m_ent_t;

  m_ent_t mq[$];
  m_ent_t m_out;
  logic   m_ov;

  task automatic do_reset();
    rst_n    = 1'b0;
    aluValid = 1'b0;
    aluReg   = '0;
    aluData  = '0;
    memValid = 1'b0;
    memReg   = '0;
    memData  = '0;
    lookupReg = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_out = '0;
    m_ov  = 1'b0;
  endtask

  // One cycle: drive at the falling edge, check against the model, then advance the
  // model across the rising edge.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic [4:0] lk, output logic a_acc, output logic m_acc);
    int          free;
    logic        e_ar;
    logic        e_mr;
    logic        e_pend;
    logic [31:0] e_ld;
    aluValid  = av;
    aluReg    = ar;
    aluData   = ad;
    memValid  = mv;
    memReg    = mr;
    memData   = md;
    lookupReg = lk;
    #1;
    free   = DEPTH - mq.size();
    e_ar   = (free >= 1);
    e_mr   = (free >= 2) || (free == 1 && !av);
    e_pend = 1'b0;
    e_ld   = '0;
    if (lk != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!e_pend && mq[i].rd == lk) begin
          e_pend = 1'b1;
          e_ld   = mq[i].data;
        end
      end
      if (!e_pend && m_ov && m_out.rd == lk) begin
        e_pend = 1'b1;
        e_ld   = m_out.data;
      end
    end
    chk("aluReady", 32'(aluReady), 32'(e_ar));
    chk("memReady", 32'(memReady), 32'(e_mr));
    chk("count", 32'(cnt), 32'(mq.size()));
    chk("regWrite", 32'(regWrite), 32'(m_ov));
    chk("writeRegister", 32'(writeRegister), 32'(m_out.rd));
    chk("writeData", writeData, m_out.data);
    chk("lookupPending", 32'(lookupPending), 32'(e_pend));
    chk("lookupData", lookupData, e_ld);
    @(posedge clk);
    a_acc = av && e_ar;
    m_acc = mv && e_mr;
    if (mq.size() > 0) begin
      m_out = mq.pop_front();
      m_ov  = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
    if (a_acc && ar != 5'd0) mq.push_back('{rd: ar, data: ad});
    if (m_acc && mr != 5'd0) mq.push_back('{rd: mr, data: md});
    @(negedge clk);
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [4:0]  lk;
    logic        e_ar;
    logic        e_mr;
    logic [2:0]  e_cnt;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_pend;
    logic [31:0] e_ld;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        aa;
    logic        ma;
    logic        pa;
    logic        pm;
    logic [4:0]  ra;
    logic [4:0]  rm;
    logic [31:0] da;
    logic [31:0] dm;
    logic [2:0]  maxc;
    int          stalls;

    // Expected values are what is visible before each rising edge.
    vt[0]  = '{1'b1, 5'd3, 32'hAA,   1'b0, 5'd0, 32'h0,  5'd3,
               1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0};
    vt[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd3,
               1'b1, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0,  1'b1, 32'hAA};
    vt[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd3,
               1'b1, 1'b1, 3'd0, 1'b1, 5'd3, 32'hAA, 1'b1, 32'hAA};
    vt[3]  = '{1'b1, 5'd4, 32'h11,   1'b1, 5'd5, 32'h22, 5'd3,
               1'b1, 1'b1, 3'd0, 1'b0, 5'd3, 32'hAA, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd5,
               1'b1, 1'b1, 3'd2, 1'b0, 5'd3, 32'hAA, 1'b1, 32'h22};
    vt[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd4,
               1'b1, 1'b1, 3'd1, 1'b1, 5'd4, 32'h11, 1'b1, 32'h11};
    vt[6]  = '{1'b1, 5'd7, 32'h1,    1'b0, 5'd0, 32'h0,  5'd7,
               1'b1, 1'b1, 3'd0, 1'b1, 5'd5, 32'h22, 1'b0, 32'h0};
    vt[7]  = '{1'b1, 5'd7, 32'h2,    1'b0, 5'd0, 32'h0,  5'd7,
               1'b1, 1'b1, 3'd1, 1'b0, 5'd5, 32'h22, 1'b1, 32'h1};
    vt[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd7,
               1'b1, 1'b1, 3'd1, 1'b1, 5'd7, 32'h1,  1'b1, 32'h2};
    vt[9]  = '{1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0,  5'd0,
               1'b1, 1'b1, 3'd0, 1'b1, 5'd7, 32'h2,  1'b0, 32'h0};
    vt[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0,
               1'b1, 1'b1, 3'd0, 1'b0, 5'd7, 32'h2,  1'b0, 32'h0};

    do_reset();
    for (int v = 0; v < NV; v++) begin
      aluValid  = vt[v].av;
      aluReg    = vt[v].ar;
      aluData   = vt[v].ad;
      memValid  = vt[v].mv;
      memReg    = vt[v].mr;
      memData   = vt[v].md;
      lookupReg = vt[v].lk;
      #1;
      chk($sformatf("vec%0d aluReady", v), 32'(aluReady), 32'(vt[v].e_ar));
      chk($sformatf("vec%0d memReady", v), 32'(memReady), 32'(vt[v].e_mr));
      chk($sformatf("vec%0d count", v), 32'(cnt), 32'(vt[v].e_cnt));
      chk($sformatf("vec%0d regWrite", v), 32'(regWrite), 32'(vt[v].e_we));
      chk($sformatf("vec%0d writeRegister", v), 32'(writeRegister), 32'(vt[v].e_wr));
      chk($sformatf("vec%0d writeData", v), writeData, vt[v].e_wd);
      chk($sformatf("vec%0d lookupPending", v), 32'(lookupPending), 32'(vt[v].e_pend));
      chk($sformatf("vec%0d lookupData", v), lookupData, vt[v].e_ld);
      @(posedge clk);
      @(negedge clk);
    end

    // Both producers offering every cycle: with one pop per edge occupancy tops out at 3,
    // after which the ALU takes the last slot and the memory offer waits.
    do_reset();
    maxc   = '0;
    stalls = 0;
    pm     = 1'b1;
    rm     = 5'd20;
    dm     = 32'hBEEF_0020;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 5'(8 + c), 32'(32'h100 + c), pm, rm, dm, 5'd20, aa, ma);
      if (cnt > maxc) maxc = cnt;
      if (ma) pm = 1'b0;
      else stalls++;
      if (!pm) begin
        pm = 1'b1;
        rm = 5'(21 + c);
        dm = 32'(32'h200 + c);
      end
    end
    chk("fill_max_count", 32'(maxc), 32'd3);
    chk("fill_mem_stall_cycles", 32'(stalls), 32'd4);
    step(1'b0, 5'd0, 32'h0, pm, rm, dm, rm, aa, ma);
    chk("mem_accept_alu_idle", 32'(ma), 32'd1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(8 + c), aa, ma);
    end

    // Reset with three entries queued and a write on the port.
    step(1'b1, 5'd10, 32'hA10, 1'b1, 5'd11, 32'hA11, 5'd10, aa, ma);
    step(1'b1, 5'd12, 32'hA12, 1'b1, 5'd13, 32'hA13, 5'd12, aa, ma);
    chk("pre_reset_count", 32'(cnt), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_writeRegister", 32'(writeRegister), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_aluReady", 32'(aluReady), 32'd1);
    chk("rst_memReady", 32'(memReady), 32'd1);
    aluValid = 1'b0;
    memValid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_out = '0;
    m_ov  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(10 + c), aa, ma);
    end

    // Randomized traffic; producers hold their offer until it is accepted.
    pa = 1'b0;
    pm = 1'b0;
    ra = '0;
    rm = '0;
    da = '0;
    dm = '0;
    for (int c = 0; c < 600; c++) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1;
        ra = 5'($urandom_range(0, 9));
        da = $urandom();
      end
      if (!pm && $urandom_range(0, 2) != 0) begin
        pm = 1'b1;
        rm = 5'($urandom_range(0, 9));
        dm = $urandom();
      end
      step(pa, ra, da, pm, rm, dm, 5'($urandom_range(0, 9)), aa, ma);
      if (aa) pa = 1'b0;
      if (ma) pm = 1'b0;
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'($urandom_range(0, 9)), aa, ma);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
